// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 8-bit words from a combinational program ROM and issues
// them to a multi-cycle processor through Run/DIN/Done, with halt, illegal-opcode and
// watchdog handling.
//
// Parameters
//   START_ADDR  PC value loaded by reset and by start
//   WDOG_MAX    EXEC cycles allowed without proc_done before a watchdog error
// Ports
//   Clk, Resetn   clock, synchronous active-low reset (shared with the processor)
//   start         one-cycle pulse, begins execution from START_ADDR (ignored while busy)
//   halt_req      stop after the current instruction completes
//   mem_data      ROM word at mem_addr
//   proc_done     processor Done
//   mem_addr      ROM address (= pc)
//   proc_din      processor DIN (= mem_data)
//   proc_run      processor Run, high for the single FETCH cycle of an issued instruction
//   pc            program counter
//   busy/halted/err  status flags for FETCH|EXEC, HALT and ERROR
//   err_code      01 illegal opcode, 10 watchdog, 00 otherwise
//   instr_count   retired instructions, saturating
module instr_sequencer #(
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter int unsigned WDOG_MAX   = 8
) (
  input  logic        Clk,
  input  logic        Resetn,
  input  logic        start,
  input  logic        halt_req,
  input  logic [7:0]  mem_data,
  input  logic        proc_done,
  output logic [7:0]  mem_addr,
  output logic [7:0]  proc_din,
  output logic        proc_run,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StHalt, StError} state_e;

  localparam logic [2:0]  OpMvi    = 3'b001;
  localparam logic [2:0]  OpHalt   = 3'b111;
  localparam logic [15:0] WdogLast = 16'(WDOG_MAX - 1);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        halt_pend_q, halt_pend_d;
  logic [15:0] wdog_q, wdog_d;

  logic [2:0]  opcode;
  logic        halt_now;

  assign opcode   = mem_data[6:4];
  // A request arriving this cycle counts as pending immediately.
  assign halt_now = halt_pend_q | halt_req;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    err_code_d  = err_code_q;
    halt_pend_d = halt_pend_q;
    wdog_d      = wdog_q;
    proc_run    = 1'b0;

    case (state_q)
      StIdle, StHalt, StError: begin
        if (start) begin
          state_d     = StFetch;
          pc_d        = START_ADDR;
          cnt_d       = 16'd0;
          err_code_d  = 2'b00;
          wdog_d      = 16'd0;
          halt_pend_d = halt_req;
        end
      end
      StFetch: begin
        wdog_d = 16'd0;
        if (halt_now || opcode == OpHalt) begin
          state_d     = StHalt;
          halt_pend_d = 1'b0;
        end else if (opcode[2]) begin
          state_d    = StError;
          err_code_d = 2'b01;
        end else begin
          proc_run = 1'b1;
          pc_d     = pc_q + 8'd1;
          op_d     = opcode;
          state_d  = StExec;
        end
      end
      StExec: begin
        halt_pend_d = halt_now;
        if (proc_done) begin
          wdog_d = 16'd0;
          cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          // mvi consumed the next word as its immediate; step over it.
          if (op_q == OpMvi) pc_d = pc_q + 8'd1;
          if (halt_now) begin
            state_d     = StHalt;
            halt_pend_d = 1'b0;
          end else begin
            state_d = StFetch;
          end
        end else if (wdog_q == WdogLast) begin
          state_d    = StError;
          err_code_d = 2'b10;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q     <= StIdle;
      pc_q        <= START_ADDR;
      op_q        <= 3'b000;
      cnt_q       <= 16'd0;
      err_code_q  <= 2'b00;
      halt_pend_q <= 1'b0;
      wdog_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      err_code_q  <= err_code_d;
      halt_pend_q <= halt_pend_d;
      wdog_q      <= wdog_d;
    end
  end

  assign mem_addr    = pc_q;
  assign proc_din    = mem_data;
  assign pc          = pc_q;
  assign busy        = (state_q == StFetch) || (state_q == StExec);
  assign halted      = (state_q == StHalt);
  assign err         = (state_q == StError);
  assign err_code    = err_code_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        Clk;
  logic        Resetn;
  logic        start, halt_req, start2;
  logic [7:0]  rom [256];

  logic [7:0]  mem_addr, proc_din, pc, mem_data;
  logic        proc_run, busy, halted, err, proc_done;
  logic [1:0]  err_code;
  logic [15:0] instr_count;

  logic [7:0]  mem_addr2, proc_din2, pc2, mem_data2;
  logic        proc_run2, busy2, halted2, err2, proc_done2;
  logic [1:0]  err_code2;
  logic [15:0] instr_count2;

  int n_cmp;
  int n_fail;

  assign mem_data  = rom[mem_addr];
  assign mem_data2 = rom[mem_addr2];

  instr_sequencer u_dut (
    .Clk(Clk), .Resetn(Resetn), .start(start), .halt_req(halt_req),
    .mem_data(mem_data), .proc_done(proc_done), .mem_addr(mem_addr), .proc_din(proc_din),
    .proc_run(proc_run), .pc(pc), .busy(busy), .halted(halted), .err(err),
    .err_code(err_code), .instr_count(instr_count)
  );

  instr_sequencer #(.START_ADDR(8'hFE), .WDOG_MAX(8)) u_dut_fe (
    .Clk(Clk), .Resetn(Resetn), .start(start2), .halt_req(1'b0),
    .mem_data(mem_data2), .proc_done(proc_done2), .mem_addr(mem_addr2),
    .proc_din(proc_din2), .proc_run(proc_run2), .pc(pc2), .busy(busy2), .halted(halted2),
    .err(err2), .err_code(err_code2), .instr_count(instr_count2)
  );

  // Small processor model: mv/mvi done in EXEC cycle 1, add/sub in EXEC cycle 3.
  logic       proc_en;
  logic [7:0] ir;
  logic [1:0] step;
  logic [7:0] r [4];
  logic [2:0] p_op;
  assign p_op      = ir[6:4];
  assign proc_done = proc_en && ((step == 2'd1 && !p_op[1]) || (step == 2'd3 && p_op[1]));

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      ir   <= 8'h00;
      step <= 2'd0;
      for (int i = 0; i < 4; i++) r[i] <= 8'h00;
    end else if (proc_run) begin
      ir   <= proc_din;
      step <= 2'd1;
    end else if (step != 2'd0) begin
      if (proc_done) begin
        step <= 2'd0;
        case (p_op)
          3'b000:  r[ir[3:2]] <= r[ir[1:0]];
          3'b001:  r[ir[3:2]] <= proc_din;
          3'b010:  r[ir[3:2]] <= r[ir[3:2]] + r[ir[1:0]];
          3'b011:  r[ir[3:2]] <= r[ir[3:2]] - r[ir[1:0]];
          default: ;
        endcase
      end else if (step != 2'd3) begin
        step <= step + 2'd1;
      end
    end
  end

  // Second instance only runs single-cycle instructions.
  always_ff @(posedge Clk) begin
    if (!Resetn) proc_done2 <= 1'b0;
    else         proc_done2 <= proc_run2;
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h70;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int max);
    for (int i = 0; i < max && !halted && !err; i++) tick();
    chk("wait_halt", {15'd0, halted}, 16'd1);
  endtask

  initial begin
    int n;
    n_cmp    = 0;
    n_fail   = 0;
    start    = 1'b0;
    start2   = 1'b0;
    halt_req = 1'b0;
    proc_en  = 1'b1;
    fill_rom();
    do_reset();

    // Reset state
    chk("rst_pc", {8'h00, pc}, 16'h0000);
    chk("rst_flags", {12'h0, proc_run, busy, halted, err}, 16'h0000);
    chk("rst_err_code", {14'd0, err_code}, 16'd0);
    chk("rst_count", instr_count, 16'd0);
    chk("rst_pc_fe", {8'h00, pc2}, 16'h00FE);

    // mvi R1,#5 then halt
    rom[0] = 8'h14; rom[1] = 8'h05; rom[2] = 8'h70;
    pulse_start();
    chk("a_fetch_run", {15'd0, proc_run}, 16'd1);
    chk("a_fetch_pc", {8'h00, pc}, 16'h0000);
    tick();
    chk("a_exec_run", {15'd0, proc_run}, 16'd0);
    chk("a_exec_din", {8'h00, proc_din}, 16'h0005);
    tick();
    tick();
    chk("a_halted", {15'd0, halted}, 16'd1);
    chk("a_pc", {8'h00, pc}, 16'h0002);
    chk("a_count", instr_count, 16'd1);
    chk("a_r1", {8'h00, r[1]}, 16'h0005);

    // Restart from HALT clears the counter
    pulse_start();
    chk("a_restart_cnt", instr_count, 16'd0);
    chk("a_restart_pc", {8'h00, pc}, 16'h0000);
    wait_halt(20);
    chk("a_restart_cnt2", instr_count, 16'd1);

    // mvi R0,#3; mvi R1,#4; add R0,R1; halt
    fill_rom();
    rom[0] = 8'h10; rom[1] = 8'h03; rom[2] = 8'h14; rom[3] = 8'h04; rom[4] = 8'h21;
    pulse_start();
    for (int i = 0; i < 20 && !(proc_run && pc == 8'h04); i++) tick();
    chk("b_add_issue", {15'd0, proc_run && pc == 8'h04}, 16'd1);
    n = 0;
    for (int i = 0; i < 20 && instr_count != 16'd3; i++) begin
      tick();
      n++;
    end
    chk("b_add_latency", 16'(n), 16'd4);
    tick();
    chk("b_halted", {15'd0, halted}, 16'd1);
    chk("b_pc", {8'h00, pc}, 16'h0005);
    chk("b_count", instr_count, 16'd3);
    chk("b_r0", {8'h00, r[0]}, 16'h0007);

    // Illegal opcode
    rom[0] = 8'h40;
    pulse_start();
    chk("c_fetch_run", {15'd0, proc_run}, 16'd0);
    tick();
    chk("c_err", {15'd0, err}, 16'd1);
    chk("c_err_code", {14'd0, err_code}, 16'd1);
    chk("c_pc", {8'h00, pc}, 16'h0000);
    rom[0] = 8'h70;
    pulse_start();
    chk("c_clear_code", {14'd0, err_code}, 16'd0);
    tick();
    chk("c_restart_halt", {15'd0, halted}, 16'd1);

    // Reset in the middle of an add
    rom[0] = 8'h21;
    pulse_start();
    tick();
    Resetn = 1'b0;
    tick();
    chk("d_rst_flags", {12'h0, proc_run, busy, halted, err}, 16'h0000);
    chk("d_rst_pc", {8'h00, pc}, 16'h0000);
    Resetn = 1'b1;

    // Watchdog, with a start pulse ignored mid-EXEC
    rom[0] = 8'h00;
    proc_en = 1'b0;
    pulse_start();
    chk("e_issue", {15'd0, proc_run}, 16'd1);
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) start = 1'b1;
      tick();
      start = 1'b0;
      chk("e_err", {15'd0, err}, {15'd0, i == 9});
      chk("e_pc", {8'h00, pc}, 16'h0001);
    end
    chk("e_err_code", {14'd0, err_code}, 16'd2);
    proc_en = 1'b1;
    do_reset();

    // halt_req in the second EXEC cycle of an add
    rom[0] = 8'h21; rom[1] = 8'h00; rom[2] = 8'h70;
    pulse_start();
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("f_still_busy", {14'd0, busy, halted}, 16'd2);
    tick();
    chk("f_halted", {15'd0, halted}, 16'd1);
    chk("f_count", instr_count, 16'd1);
    chk("f_pc", {8'h00, pc}, 16'h0001);
    tick();
    chk("f_no_issue", {14'd0, proc_run, halted}, 16'd1);

    // start and halt_req together in IDLE
    do_reset();
    rom[0] = 8'h00;
    start = 1'b1;
    halt_req = 1'b1;
    tick();
    start = 1'b0;
    halt_req = 1'b0;
    chk("g_fetch", {14'd0, busy, proc_run}, 16'd2);
    tick();
    chk("g_halted", {15'd0, halted}, 16'd1);
    chk("g_count", instr_count, 16'd0);

    // PC wrap on the START_ADDR=FE instance
    fill_rom();
    rom[8'hFE] = 8'h00; rom[8'hFF] = 8'h14; rom[8'h00] = 8'h07; rom[8'h01] = 8'h70;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("h_issue_fe", {7'd0, proc_run2, pc2}, 16'h01FE);
    for (int i = 0; i < 20 && !halted2 && !err2; i++) tick();
    chk("h_halted", {14'd0, halted2, err2}, 16'd2);
    chk("h_pc", {8'h00, pc2}, 16'h0001);
    chk("h_count", instr_count2, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
